spike_mac_seq: RTL and testbench
================================

Name: spike_mac_seq

Overview:
Parametrised, time-multiplexed spike-weighted accumulator; successor to the single-shot combinational mac.
Consumes an N_IN-wide binary spike vector and N_IN packed unsigned weights, processing LANES inputs per cycle.
Produces a saturating sum and a threshold-compare output spike.
Optional integrate mode keeps the accumulator across frames (membrane potential) and resets it on fire.
Sits between the spike-input stage and the neuron output/spike routing logic.

Parameters:
N_IN, 25, number of synaptic inputs (spike bits / weights)
W_W, 16, weight width (unsigned)
LANES, 5, inputs accumulated per clock; 1..N_IN, need not divide N_IN
ACC_W, 21, accumulator/sum width; saturating
ACCUM_MODE, 0, 0 = accumulator cleared at every start; 1 = accumulator persists across frames and clears after a spike

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  frame request; sampled only in IDLE
clear_acc  in  1  zero accumulator and overflow flag; honoured only in IDLE
p  in  N_IN  spike vector; bit i gates weight i
w  in  N_IN*W_W  packed weights; weight i = w[i*W_W +: W_W]
threshold  in  ACC_W  fire threshold; sampled with start
busy  out  1  high from the cycle after start acceptance until done
done  out  1  one-cycle pulse; sum and spike valid
sum  out  ACC_W  frame result; held between frames
spike  out  1  one-cycle pulse with done when result >= threshold
overflow  out  1  sticky saturation flag

Behaviour:
- Reset (rst high at an edge): state IDLE; busy, done, spike, overflow, sum, accumulator, step counter all 0. Applies mid-frame: the frame is abandoned, no done is issued.
- NUM_STEPS = ceil(N_IN/LANES).
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE, start=1 at edge E0:
  - capture p, w, threshold into internal registers; later input changes do not affect the frame.
  - step=0; accumulator cleared if ACCUM_MODE=0; busy=1; go to RUN.
- RUN, edges E1..E_NUM_STEPS:
  - each step adds the partial sum of lanes [step*LANES, step*LANES+LANES-1] into the accumulator; lane k contributes w_k if p_k=1, else 0.
  - indices >= N_IN are masked to 0 on the last step.
  - partial-sum width is W_W+clog2(LANES+1).
  - accumulator add saturates at 2^ACC_W-1; a saturating add sets overflow=1 (sticky).
  - after the last step, go to DONE.
- DONE, one cycle visible after edge E_NUM_STEPS:
  - sum = accumulator; spike = (accumulator >= threshold), unsigned, inclusive; done=1; busy=0 at this same edge.
  - ACCUM_MODE=1 and spike: accumulator clears to 0 at the next edge; sum keeps the pre-clear value.
  - next edge: state IDLE; done=0; spike=0.
- Latency: done is sampled high at edge E_(NUM_STEPS+1). Default parameters give 5 steps, done at the 6th edge after the start edge.
- Back-to-back frames: start is accepted in IDLE only, so the minimum frame period is NUM_STEPS+2 cycles. start while busy/DONE is ignored and not queued.
- clear_acc in IDLE:
  - zeroes accumulator and overflow; sum output is unchanged.
  - simultaneous with start, the clear applies first and the frame starts from 0.
  - clear_acc outside IDLE is ignored.
- overflow clears only on rst or clear_acc.

Decomposition:
- Package spike_mac_pkg:
  - clog2 function
  - state encoding localparams (IDLE, RUN, DONE)
  - derived width helper for partial sums
- Sub-module spike_lane_adder:
  - combinational masked adder over LANES (spike bits, weights, valid mask) -> partial sum.
  - instantiated once and used every RUN cycle.

Test Plan:
1. Default parameters, ACCUM_MODE=0.
   - Weights 1,1,5,1,8,6,5,2,5,1,3,1,2,3,7,5,4,2,4,6,7,8,4,3,2.
   - Spikes 1,1,1,1,0,0,0,1,0,1,1,0,1,0,0,1,0,1,1,1,0,1,0,1,1 (index 0..24).
   - threshold=50 -> done at the 6th edge after start, sum=46, spike=0.
2. Same vectors, threshold=46 -> sum=46, spike=1 (inclusive compare).
3. ACCUM_MODE=1, threshold=80, three frames with the same vectors -> sum 46/spike 0, then 92/spike 1, then 46/spike 0 (accumulator cleared after fire).
4. All p=1, all w=16'hFFFF.
   - ACCUM_MODE=0 -> sum=1638375, overflow=0.
   - ACCUM_MODE=1, second frame -> sum=2097151, overflow=1.
   - clear_acc in IDLE -> overflow=0.
5. Hold start high continuously -> frames start every 7 cycles, extra pulses ignored. rst at the 3rd RUN edge -> busy=0, done never pulses, sum=0.
6. LANES=4 with the vectors of test 1 -> 7 steps, done at the 8th edge, sum=46 (masked tail lanes contribute 0).

Source files
------------

// File: rtl/spike_mac_pkg.sv
// Shared constants and elaboration-time helpers for the sequential spike-weighted accumulator.
package spike_mac_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Wide enough to hold LANES full-scale weights without wrapping.
  function automatic int psum_width(input int w_w, input int lanes);
    return w_w + clog2(lanes + 1);
  endfunction

endpackage

// File: rtl/spike_mac_seq_if.sv
// Frame request / result bundle between the spike-input stage and the accumulator.
interface spike_mac_seq_if #(
  parameter int N_IN  = 25,
  parameter int W_W   = 16,
  parameter int ACC_W = 21
);
  logic                  start;
  logic                  clear_acc;
  logic [N_IN-1:0]       p;
  logic [N_IN*W_W-1:0]   w;
  logic [ACC_W-1:0]      threshold;
  logic                  busy;
  logic                  done;
  logic [ACC_W-1:0]      sum;
  logic                  spike;
  logic                  overflow;

  modport master (
    output start, clear_acc, p, w, threshold,
    input  busy, done, sum, spike, overflow
  );

  modport slave (
    input  start, clear_acc, p, w, threshold,
    output busy, done, sum, spike, overflow
  );
endinterface

// File: rtl/spike_lane_adder.sv
// Combinational masked adder: sums the weights of the active, valid lanes of one step.
module spike_lane_adder
  import spike_mac_pkg::*;
#(
  parameter int LANES = 5,
  parameter int W_W   = 16,
  parameter int PS_W  = psum_width(W_W, LANES)
) (
  input  logic [LANES-1:0]     spk_i,
  input  logic [LANES*W_W-1:0] wts_i,
  input  logic [LANES-1:0]     valid_i,
  output logic [PS_W-1:0]      psum_o
);

  always_comb begin
    // NOTE: the default assignment before the loop keeps this block free of latches.
    psum_o = '0;
    for (int k = 0; k < LANES; k++) begin
      if (spk_i[k] && valid_i[k]) psum_o = psum_o + PS_W'(wts_i[k*W_W +: W_W]);
    end
  end

endmodule

// File: rtl/spike_mac_seq.sv
// Time-multiplexed spike-weighted accumulator: LANES inputs per cycle, saturating sum,
// threshold spike, and an optional integrate mode that keeps the potential across frames.
module spike_mac_seq
  import spike_mac_pkg::*;
#(
  parameter int N_IN       = 25,
  parameter int W_W        = 16,
  parameter int LANES      = 5,
  parameter int ACC_W      = 21,
  parameter int ACCUM_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  spike_mac_seq_if.slave   bus
);

  localparam int NUM_STEPS = (N_IN + LANES - 1) / LANES;
  localparam int PAD_N     = NUM_STEPS * LANES;
  localparam int PS_W      = psum_width(W_W, LANES);
  localparam int STEP_W    = clog2(NUM_STEPS + 1);
  localparam int EXT_W     = ((ACC_W > PS_W) ? ACC_W : PS_W) + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  logic [1:0]          state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [N_IN-1:0]     p_q, p_d;
  logic [N_IN*W_W-1:0] w_q, w_d;
  logic [ACC_W-1:0]    thr_q, thr_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ACC_W-1:0]    sum_q, sum_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                spike_q, spike_d;
  logic                ovf_q, ovf_d;

  logic [PAD_N-1:0]     p_pad;
  logic [PAD_N*W_W-1:0] w_pad;
  logic [LANES-1:0]     lane_p;
  logic [LANES*W_W-1:0] lane_w;
  logic [LANES-1:0]     lane_v;
  logic [PS_W-1:0]      psum;
  logic [EXT_W-1:0]     acc_ext;
  logic                 sat;
  logic [ACC_W-1:0]     acc_next;

  // Padding to whole steps lets every step use the same constant-width slice.
  assign p_pad = PAD_N'(p_q);
  assign w_pad = (PAD_N*W_W)'(w_q);

  always_comb begin
    lane_p = '0;
    lane_w = '0;
    lane_v = '0;
    for (int s = 0; s < NUM_STEPS; s++) begin
      if (step_q == STEP_W'(s)) begin
        lane_p = p_pad[s*LANES +: LANES];
        lane_w = w_pad[s*LANES*W_W +: LANES*W_W];
        for (int k = 0; k < LANES; k++) lane_v[k] = (s*LANES + k) < N_IN;
      end
    end
  end

  spike_lane_adder #(.LANES(LANES), .W_W(W_W), .PS_W(PS_W)) u_lane_adder (
    .spk_i   (lane_p),
    .wts_i   (lane_w),
    .valid_i (lane_v),
    .psum_o  (psum)
  );

  assign acc_ext  = EXT_W'(acc_q) + EXT_W'(psum);
  assign sat      = |acc_ext[EXT_W-1:ACC_W];
  assign acc_next = sat ? ACC_MAX : acc_ext[ACC_W-1:0];

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    p_d     = p_q;
    w_d     = w_q;
    thr_d   = thr_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    busy_d  = busy_q;
    done_d  = done_q;
    spike_d = spike_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        done_d  = 1'b0;
        spike_d = 1'b0;
        // Clear is evaluated first so a simultaneous start begins from zero.
        if (bus.clear_acc) begin
          acc_d = '0;
          ovf_d = 1'b0;
        end
        if (bus.start) begin
          p_d     = bus.p;
          w_d     = bus.w;
          thr_d   = bus.threshold;
          step_d  = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
          if (ACCUM_MODE == 0) acc_d = '0;
        end
      end
      ST_RUN: begin
        acc_d  = acc_next;
        ovf_d  = ovf_q | sat;
        step_d = step_q + STEP_W'(1);
        if (step_q == STEP_W'(NUM_STEPS - 1)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sum_d   = acc_next;
          spike_d = (acc_next >= thr_q);
        end
      end
      ST_DONE: begin
        done_d  = 1'b0;
        spike_d = 1'b0;
        state_d = ST_IDLE;
        if (ACCUM_MODE != 0 && spike_q) acc_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      spike_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      spike_q <= spike_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: capture registers carry no reset; they are only read after a start reloads them.
  always_ff @(posedge clk) begin
    p_q   <= p_d;
    w_q   <= w_d;
    thr_q <= thr_d;
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.spike    = spike_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_spike_mac_seq.sv
// Self-checking bench: three accumulator instances (clear mode, integrate mode, LANES=4)
// driven from a vector table, hand-written corner sequences and a random model comparison.
module tb_spike_mac_seq;

  localparam int N_IN  = 25;
  localparam int W_W   = 16;
  localparam int ACC_W = 21;
  localparam longint ACC_MAX = 64'd2097151;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_s   [3];
  logic                start_s [3];
  logic                clear_s [3];
  logic [N_IN-1:0]     p_s;
  logic [N_IN*W_W-1:0] w_s;
  logic [ACC_W-1:0]    thr_s;

  logic                busy_a  [3];
  logic                done_a  [3];
  logic                spike_a [3];
  logic                ovf_a   [3];
  logic [ACC_W-1:0]    sum_a   [3];

  spike_mac_seq_if #(.N_IN(N_IN), .W_W(W_W), .ACC_W(ACC_W)) bus0 ();
  spike_mac_seq_if #(.N_IN(N_IN), .W_W(W_W), .ACC_W(ACC_W)) bus1 ();
  spike_mac_seq_if #(.N_IN(N_IN), .W_W(W_W), .ACC_W(ACC_W)) bus2 ();

  assign bus0.start = start_s[0];  assign bus0.clear_acc = clear_s[0];
  assign bus1.start = start_s[1];  assign bus1.clear_acc = clear_s[1];
  assign bus2.start = start_s[2];  assign bus2.clear_acc = clear_s[2];
  assign bus0.p = p_s;  assign bus0.w = w_s;  assign bus0.threshold = thr_s;
  assign bus1.p = p_s;  assign bus1.w = w_s;  assign bus1.threshold = thr_s;
  assign bus2.p = p_s;  assign bus2.w = w_s;  assign bus2.threshold = thr_s;

  assign busy_a[0] = bus0.busy;  assign done_a[0] = bus0.done;  assign spike_a[0] = bus0.spike;
  assign busy_a[1] = bus1.busy;  assign done_a[1] = bus1.done;  assign spike_a[1] = bus1.spike;
  assign busy_a[2] = bus2.busy;  assign done_a[2] = bus2.done;  assign spike_a[2] = bus2.spike;
  assign ovf_a[0]  = bus0.overflow;  assign sum_a[0] = bus0.sum;
  assign ovf_a[1]  = bus1.overflow;  assign sum_a[1] = bus1.sum;
  assign ovf_a[2]  = bus2.overflow;  assign sum_a[2] = bus2.sum;

  spike_mac_seq #(.N_IN(N_IN), .W_W(W_W), .LANES(5), .ACC_W(ACC_W), .ACCUM_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst_s[0]), .bus(bus0.slave));
  spike_mac_seq #(.N_IN(N_IN), .W_W(W_W), .LANES(5), .ACC_W(ACC_W), .ACCUM_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst_s[1]), .bus(bus1.slave));
  spike_mac_seq #(.N_IN(N_IN), .W_W(W_W), .LANES(4), .ACC_W(ACC_W), .ACCUM_MODE(0)) u_dut2 (
    .clk(clk), .rst(rst_s[2]), .bus(bus2.slave));

  // Edge (counted from the start edge) at which done is sampled high: ceil(25/LANES)+1.
  int mode_of [3] = '{0, 1, 0};
  int lat_of  [3] = '{6, 6, 8};

  longint m_acc [3];
  bit     m_ovf [3];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string               name;
    int                  dut;
    int                  clr;        // 0 none, 1 pulse before start, 2 together with start
    logic [N_IN-1:0]     p;
    logic [N_IN*W_W-1:0] w;
    logic [ACC_W-1:0]    thr;
    logic [ACC_W-1:0]    exp_sum;
    logic                exp_spike;
    logic                exp_ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference: whole-frame weighted sum, then a saturating add onto the running potential.
  task automatic model_frame(inout vec_t v);
    longint tot;
    longint s;
    int d;
    d = v.dut;
    tot = 0;
    for (int i = 0; i < N_IN; i++)
      if (v.p[i]) tot += longint'(v.w[i*W_W +: W_W]);
    if (v.clr != 0) begin
      m_acc[d] = 0;
      m_ovf[d] = 1'b0;
    end
    s = ((mode_of[d] != 0) ? m_acc[d] : 0) + tot;
    if (s > ACC_MAX) begin
      s = ACC_MAX;
      m_ovf[d] = 1'b1;
    end
    v.exp_sum   = ACC_W'(s);
    v.exp_spike = (s >= longint'(v.thr));
    v.exp_ovf   = m_ovf[d];
    m_acc[d]    = (mode_of[d] != 0 && v.exp_spike) ? 0 : s;
  endtask

  task automatic do_frame(input vec_t v);
    int d;
    int lat;
    bit seen;
    d = v.dut;
    @(negedge clk);
    if (v.clr == 1) begin
      clear_s[d] = 1'b1;
      @(negedge clk);
      clear_s[d] = 1'b0;
    end
    p_s = v.p;
    w_s = v.w;
    thr_s = v.thr;
    start_s[d] = 1'b1;
    if (v.clr == 2) clear_s[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_s[d] = 1'b0;
    clear_s[d] = 1'b0;
    // Inputs are scrambled after the start edge; the frame must use the captured copy.
    p_s = ~v.p;
    w_s = ~v.w;
    thr_s = ~v.thr;
    check({v.name, " busy"}, busy_a[d], 1);
    seen = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_a[d]) begin
        seen = 1'b1;
        lat = n + 1;
      end
    end
    check({v.name, " done_seen"}, seen, 1);
    if (seen) begin
      check({v.name, " latency"}, lat, lat_of[d]);
      check({v.name, " sum"}, sum_a[d], v.exp_sum);
      check({v.name, " spike"}, spike_a[d], v.exp_spike);
      check({v.name, " overflow"}, ovf_a[d], v.exp_ovf);
      check({v.name, " busy_at_done"}, busy_a[d], 0);
      @(posedge clk);
      @(negedge clk);
      check({v.name, " done_pulse"}, done_a[d], 0);
      check({v.name, " spike_pulse"}, spike_a[d], 0);
      check({v.name, " sum_held"}, sum_a[d], v.exp_sum);
    end
  endtask

  function automatic vec_t mk(input string name, input int dut, input int clr,
                              input logic [N_IN-1:0] p, input logic [N_IN*W_W-1:0] w,
                              input logic [ACC_W-1:0] thr, input logic [ACC_W-1:0] es,
                              input logic esp, input logic eo);
    vec_t v;
    v.name = name; v.dut = dut; v.clr = clr; v.p = p; v.w = w; v.thr = thr;
    v.exp_sum = es; v.exp_spike = esp; v.exp_ovf = eo;
    return v;
  endfunction

  initial begin
    int wt [N_IN] = '{1,1,5,1,8,6,5,2,5,1,3,1,2,3,7,5,4,2,4,6,7,8,4,3,2};
    int sp [N_IN] = '{1,1,1,1,0,0,0,1,0,1,1,0,1,0,0,1,0,1,1,1,0,1,0,1,1};
    logic [N_IN-1:0]     tp;
    logic [N_IN*W_W-1:0] tw;
    logic [N_IN-1:0]     all_p;
    logic [N_IN*W_W-1:0] all_w;
    logic [ACC_W-1:0]    thr_max;
    vec_t v;

    for (int i = 0; i < N_IN; i++) begin
      tp[i] = sp[i][0];
      tw[i*W_W +: W_W] = W_W'(wt[i]);
    end
    all_p = '1;
    all_w = '1;
    thr_max = '1;

    for (int d = 0; d < 3; d++) begin
      rst_s[d] = 1'b1;
      start_s[d] = 1'b0;
      clear_s[d] = 1'b0;
    end
    p_s = '0;
    w_s = '0;
    thr_s = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) rst_s[d] = 1'b0;

    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset%0d busy", d), busy_a[d], 0);
      check($sformatf("reset%0d done", d), done_a[d], 0);
      check($sformatf("reset%0d spike", d), spike_a[d], 0);
      check($sformatf("reset%0d overflow", d), ovf_a[d], 0);
      check($sformatf("reset%0d sum", d), sum_a[d], 0);
    end

    tbl.push_back(mk("clr_thr50",     0, 0, tp,    tw,    21'd50,  21'd46,      1'b0, 1'b0));
    tbl.push_back(mk("clr_thr46",     0, 0, tp,    tw,    21'd46,  21'd46,      1'b1, 1'b0));
    tbl.push_back(mk("lanes4",        2, 0, tp,    tw,    21'd50,  21'd46,      1'b0, 1'b0));
    tbl.push_back(mk("clr_fullscale", 0, 0, all_p, all_w, 21'd0,   21'd1638375, 1'b1, 1'b0));
    tbl.push_back(mk("int_f1",        1, 0, tp,    tw,    21'd80,  21'd46,      1'b0, 1'b0));
    tbl.push_back(mk("int_f2_fire",   1, 0, tp,    tw,    21'd80,  21'd92,      1'b1, 1'b0));
    tbl.push_back(mk("int_f3_after",  1, 0, tp,    tw,    21'd80,  21'd46,      1'b0, 1'b0));
    tbl.push_back(mk("int_clr_start", 1, 2, tp,    tw,    21'd80,  21'd46,      1'b0, 1'b0));
    tbl.push_back(mk("int_full_a",    1, 1, all_p, all_w, thr_max, 21'd1638375, 1'b0, 1'b0));
    tbl.push_back(mk("int_full_sat",  1, 0, all_p, all_w, thr_max, 21'd2097151, 1'b1, 1'b1));
    foreach (tbl[i]) do_frame(tbl[i]);

    // Overflow stays set after the frame; clear_acc drops it but leaves sum alone.
    @(negedge clk);
    check("sticky overflow", ovf_a[1], 1);
    clear_s[1] = 1'b1;
    @(negedge clk);
    clear_s[1] = 1'b0;
    check("clear overflow", ovf_a[1], 0);
    check("clear keeps sum", sum_a[1], 21'd2097151);

    // start held high: a new frame every NUM_STEPS+2 cycles, extra requests dropped.
    begin
      int first;
      int prev;
      int cnt;
      bit gap_ok;
      first = -1; prev = -1; cnt = 0; gap_ok = 1'b1;
      @(negedge clk);
      p_s = tp; w_s = tw; thr_s = 21'd50;
      start_s[0] = 1'b1;
      for (int n = 0; n <= 27; n++) begin
        @(posedge clk);
        @(negedge clk);
        if (done_a[0]) begin
          if (first < 0) first = n;
          else if (n - prev != 7) gap_ok = 1'b0;
          prev = n;
          cnt++;
        end
      end
      start_s[0] = 1'b0;
      check("b2b first done edge", first + 1, 6);
      check("b2b frame count", cnt, 4);
      check("b2b period 7", gap_ok, 1);
    end

    // Reset on the third RUN edge abandons the frame.
    begin
      int dones;
      dones = 0;
      @(negedge clk);
      @(negedge clk);
      check("pre-reset sum", sum_a[0], 21'd46);
      p_s = tp; w_s = tw; thr_s = 21'd0;
      start_s[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_s[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_s[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst_s[0] = 1'b0;
      check("midreset busy", busy_a[0], 0);
      check("midreset sum", sum_a[0], 0);
      check("midreset overflow", ovf_a[0], 0);
      for (int n = 0; n < 12; n++) begin
        @(posedge clk);
        @(negedge clk);
        if (done_a[0]) dones++;
      end
      check("midreset no done", dones, 0);
    end

    // Random frames against the reference model; all three units are clean at this point.
    for (int d = 0; d < 3; d++) begin
      m_acc[d] = 0;
      m_ovf[d] = 1'b0;
    end
    for (int r = 0; r < 30; r++) begin
      v.name = $sformatf("rand%0d", r);
      v.dut = r % 3;
      v.clr = (v.dut == 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      v.p = N_IN'({$urandom, $urandom});
      for (int i = 0; i < N_IN; i++)
        v.w[i*W_W +: W_W] = (r % 2 == 0) ? W_W'($urandom) : W_W'($urandom_range(0, 15));
      v.thr = (r % 4 < 2) ? ACC_W'($urandom_range(0, 200)) : ACC_W'($urandom_range(0, 2097151));
      model_frame(v);
      do_frame(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
